// File: rtl/chrisruk_apa102_tx_pkg.sv
// Shared constants, FSM encoding and LED frame helper for the APA102 strip transmitter.
package chrisruk_apa102_tx_pkg;
  localparam int         START_BITS     = 32;
  localparam int         LED_FRAME_BITS = 32;
  localparam logic [2:0] LED_HDR        = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_PIXEL = 2'd2,
    ST_END   = 2'd3
  } state_t;

  function automatic logic [31:0] led_frame(input logic [4:0] bright,
                                            input logic [7:0] b,
                                            input logic [7:0] g,
                                            input logic [7:0] r);
    return {LED_HDR, bright, b, g, r};
  endfunction
endpackage

// File: rtl/chrisruk_led_bit_timer.sv
// Bit-slot timer: low half then high half, CLK_DIV cycles each; frozen while stalled.
module chrisruk_led_bit_timer #(
  parameter int CLK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  input  logic i_stall,
  output logic o_led_clk,
  output logic o_slot_start,
  output logic o_rise,
  output logic o_slot_end
);
  localparam int DW = $clog2(CLK_DIV + 1);

  logic [DW-1:0] r_div;
  logic          r_phase;
  logic          w_last;
  logic          w_run;

  assign w_last = (r_div == DW'(CLK_DIV - 1));
  assign w_run  = i_en & ~i_stall;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div   <= '0;
      r_phase <= 1'b0;
    end else if (!i_en) begin
      r_div   <= '0;
      r_phase <= 1'b0;
    end else if (!i_stall) begin
      if (w_last) begin
        r_div   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  assign o_led_clk    = r_phase;
  assign o_slot_start = w_run & ~r_phase & (r_div == '0);
  assign o_rise       = w_run & ~r_phase & w_last;
  assign o_slot_end   = w_run &  r_phase & w_last;
endmodule

// File: rtl/chrisruk_apa102_tx.sv
// APA102 transmitter: zero start frame, NUM_LEDS pixel frames MSB-first, END_BITS zero bits.
module chrisruk_apa102_tx
  import chrisruk_apa102_tx_pkg::*;
#(
  parameter int NUM_LEDS = 64,
  parameter int END_BITS = 64,
  parameter int CLK_DIV  = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_frame_start,
  input  logic [31:0] i_pixel_data,
  input  logic        i_pixel_valid,
  output logic        o_pixel_ready,
  output logic        o_led_clk,
  output logic        o_led_data,
  output logic        o_busy,
  output logic        o_frame_done
);
  localparam int PW = $clog2(NUM_LEDS + 1);
  localparam int BW = ($clog2(END_BITS) > 6) ? $clog2(END_BITS) : 6;

  state_t                    r_state;
  logic [BW-1:0]             r_bit;
  logic [PW-1:0]             r_pix;
  logic [LED_FRAME_BITS-2:0] r_sh;
  logic                      r_led_data;
  logic                      r_wait;

  logic w_slot_start, w_rise, w_slot_end, w_led_clk;
  logic w_boundary, w_take, w_last_end;
  logic w_unused_strobes;

  chrisruk_led_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_en         (r_state != ST_IDLE),
    .i_stall      (r_wait),
    .o_led_clk    (w_led_clk),
    .o_slot_start (w_slot_start),
    .o_rise       (w_rise),
    .o_slot_end   (w_slot_end)
  );
  assign w_unused_strobes = w_slot_start ^ w_rise;

  // Data is decided on the last cycle of the preceding slot so it is already
  // on the wire for the whole low half, even at CLK_DIV=1.
  assign w_boundary = (r_state == ST_PIXEL) && w_slot_end && (r_bit == BW'(LED_FRAME_BITS - 1));
  assign w_take     = (r_state == ST_PIXEL) && i_pixel_valid &&
                      (r_wait || (w_boundary && (r_pix != PW'(NUM_LEDS))));
  assign w_last_end = (r_state == ST_END) && w_slot_end && (r_bit == BW'(END_BITS - 1));

  // The final start-frame slot is carried by PIXEL (bit 31, nothing loaded) so
  // the first pixel handshake happens inside PIXEL like all the others.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_bit      <= '0;
      r_pix      <= '0;
      r_sh       <= '0;
      r_led_data <= 1'b0;
      r_wait     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_frame_start) begin
            r_state    <= ST_START;
            r_bit      <= '0;
            r_pix      <= '0;
            r_sh       <= '0;
            r_led_data <= 1'b0;
            r_wait     <= 1'b0;
          end
        end
        ST_START: begin
          if (w_slot_end) begin
            if (r_bit == BW'(START_BITS - 2)) begin
              r_state <= ST_PIXEL;
              r_bit   <= BW'(LED_FRAME_BITS - 1);
            end else begin
              r_bit <= r_bit + BW'(1);
            end
          end
        end
        ST_PIXEL: begin
          if (w_take) begin
            r_sh       <= i_pixel_data[LED_FRAME_BITS-2:0];
            r_led_data <= i_pixel_data[LED_FRAME_BITS-1];
            r_bit      <= '0;
            r_pix      <= r_pix + PW'(1);
            r_wait     <= 1'b0;
          end else if (w_boundary) begin
            if (r_pix == PW'(NUM_LEDS)) begin
              r_state    <= ST_END;
              r_bit      <= '0;
              r_led_data <= 1'b0;
            end else begin
              r_wait <= 1'b1;
            end
          end else if (w_slot_end) begin
            r_sh       <= {r_sh[LED_FRAME_BITS-3:0], 1'b0};
            r_led_data <= r_sh[LED_FRAME_BITS-2];
            r_bit      <= r_bit + BW'(1);
          end
        end
        ST_END: begin
          if (w_slot_end) begin
            if (w_last_end) begin
              r_state <= ST_IDLE;
              r_bit   <= '0;
            end else begin
              r_bit <= r_bit + BW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_pixel_ready = w_take;
  assign o_led_clk     = w_led_clk;
  assign o_led_data    = r_led_data;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_frame_done  = w_last_end;
endmodule
